// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
package mdu_pkg;

    // Operation codes presented by the EX stage.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    // Sequencer states of the unit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    // One quotient bit is produced per divide step.
    localparam int DIV_STEPS = 32;

    // Two's complement negate, wrapping modulo 2^32 (so 0x80000000 maps to itself).
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // True for the two divide ops.
    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Iterative unsigned 32/32 restoring divider, one quotient bit per step.
// Signs are handled by the caller; this core only sees magnitudes.
module div_radix2
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic [5:0]  r_steps;

    logic [32:0] w_trial;
    logic [31:0] w_diff;
    logic        w_ge;

    // Trial subtraction on the 33-bit shifted partial remainder. When the trial
    // fits, the true difference is below the divisor, so 32 bits hold it exactly.
    always_comb begin
        w_trial = {r_rem, r_quo[31]};
        w_ge    = (w_trial >= {1'b0, r_dvs});
        w_diff  = w_trial[31:0] - r_dvs;
    end

    // Load operands, then shift one dividend bit in and one quotient bit out per step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_steps <= '0;
        end else if (load) begin
            r_quo   <= dividend;
            r_rem   <= '0;
            r_dvs   <= divisor;
            r_steps <= '0;
        end else if (step && !done) begin
            r_rem   <= w_ge ? w_diff : w_trial[31:0];
            r_quo   <= {r_quo[30:0], w_ge};
            r_steps <= r_steps + 6'd1;
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign done      = (r_steps == 6'(DIV_STEPS));

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with HI/LO registers, issued from EX.
// busy is combinational in the issue cycle so a dependent MFHI/MFLO in ID stalls at once.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  r_state;
    mdu_state_e  w_state_next;
    logic [4:0]  r_count;
    logic [4:0]  w_count_next;

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Latched multiply operands and signedness.
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic        r_mul_signed;

    // Sign fix-up flags captured when a divide is issued.
    logic        r_q_neg;
    logic        r_r_neg;

    logic        w_idle;
    logic        w_start_ok;
    logic        w_mt_ok;
    logic        w_div_load;
    logic        w_div_step;
    logic        w_wr_mul;
    logic        w_wr_fix;

    logic [31:0] w_div_a;
    logic [31:0] w_div_b;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_div_done;

    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_fix_q;
    logic [31:0] w_fix_r;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_start_ok = start && !cancel && w_idle && is_muldiv(op);
    assign w_mt_ok    = start && !cancel && w_idle;
    assign busy       = w_start_ok || !w_idle;
    assign hi         = r_hi;
    assign lo         = r_lo;

    // Signed divide works on magnitudes; 0x80000000 stays itself and is read unsigned.
    always_comb begin
        w_div_a = src_a;
        w_div_b = src_b;
        if (op == OP_DIV) begin
            if (src_a[31]) w_div_a = neg32(src_a);
            if (src_b[31]) w_div_b = neg32(src_b);
        end
    end

    div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (w_div_load),
        .step      (w_div_step),
        .dividend  (w_div_a),
        .divisor   (w_div_b),
        .quotient  (w_quo),
        .remainder (w_rem),
        .done      (w_div_done)
    );

    // Full 64-bit product; sign- or zero-extending to 64 bits makes one multiplier serve both.
    always_comb begin
        w_ext_a = r_mul_signed ? {{32{r_mul_a[31]}}, r_mul_a} : {32'd0, r_mul_a};
        w_ext_b = r_mul_signed ? {{32{r_mul_b[31]}}, r_mul_b} : {32'd0, r_mul_b};
        w_prod  = w_ext_a * w_ext_b;
    end

    // Apply quotient and remainder signs for the FIX cycle.
    always_comb begin
        w_fix_q = r_q_neg ? neg32(w_quo) : w_quo;
        w_fix_r = r_r_neg ? neg32(w_rem) : w_rem;
    end

    // Next-state and control decode; cancel always returns to IDLE without a write.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_div_load   = 1'b0;
        w_div_step   = 1'b0;
        w_wr_mul     = 1'b0;
        w_wr_fix     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    if (is_div(op)) begin
                        w_state_next = ST_DIV;
                        w_count_next = 5'(DIV_STEPS - 1);
                        w_div_load   = 1'b1;
                    end else begin
                        w_state_next = ST_MUL;
                        w_count_next = 5'(MUL_LAT - 1);
                    end
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    w_state_next = ST_IDLE;
                end else if (r_count == 5'd0) begin
                    w_wr_mul     = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_count_next = r_count - 5'd1;
                end
            end
            ST_DIV: begin
                w_div_step = 1'b1;
                if (cancel) begin
                    w_state_next = ST_IDLE;
                end else if (r_count == 5'd0) begin
                    w_state_next = ST_FIX;
                end else begin
                    w_count_next = r_count - 5'd1;
                end
            end
            ST_FIX: begin
                w_wr_fix     = !cancel && w_div_done;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and step counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Capture operands and sign flags at issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_signed <= 1'b0;
            r_q_neg      <= 1'b0;
            r_r_neg      <= 1'b0;
        end else if (w_start_ok) begin
            if (is_div(op)) begin
                r_q_neg <= (op == OP_DIV) && (src_a[31] ^ src_b[31]);
                r_r_neg <= (op == OP_DIV) && src_a[31];
            end else begin
                r_mul_a      <= src_a;
                r_mul_b      <= src_b;
                r_mul_signed <= (op == OP_MULT);
            end
        end
    end

    // HI/LO update: completed multiply, completed divide, or a direct move while idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_wr_mul) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
        end else if (w_wr_fix) begin
            r_hi <= w_fix_r;
            r_lo <= w_fix_q;
        end else if (w_mt_ok && (op == OP_MTHI)) begin
            r_hi <= src_a;
        end else if (w_mt_ok && (op == OP_MTLO)) begin
            r_lo <= src_a;
        end
    end

endmodule
